// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants, types and the round-robin pick helper for
//               the 4:1 round-robin arbiter (rr_arb_4to1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    // Pointer reset value: "last winner" is d, so requester a wins first
    localparam logic [SEL_W-1:0] PTR_RST = 2'b11;

    // Requester index constants (bit position in req, binary value of s1)
    localparam logic [SEL_W-1:0] REQ_A = 2'd0;
    localparam logic [SEL_W-1:0] REQ_B = 2'd1;
    localparam logic [SEL_W-1:0] REQ_C = 2'd2;
    localparam logic [SEL_W-1:0] REQ_D = 2'd3;

    // IDLE: no word held, HOLD: o/s1 carry an unconsumed word
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First asserted request scanning upward from ptr+1, wrapping 3->0.
    // The 2-bit addition wraps naturally; k=N_REQ revisits ptr itself last.
    function automatic rr_pick_t rr_pick(input logic [N_REQ-1:0] req,
                                         input logic [SEL_W-1:0] ptr);
        rr_pick_t         pick;
        logic [SEL_W-1:0] cand;
        pick.found = 1'b0;
        pick.idx   = ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_4to1_if.sv
// ============================================================================
// Module      : rr_arb_4to1_if
// Description : Request/data/output handshake bundle of the 4:1 round-robin
//               arbiter. Optional macro RR_ARB_LOCK_EN adds the lock input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arb_4to1_if #(
    parameter int WIDTH = 32
);
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] s1;
    logic [WIDTH-1:0] o;
    logic             o_valid;
    logic             o_ready;
`ifdef RR_ARB_LOCK_EN
    logic             lock;
`endif

    // Requesters and downstream consumer side
    modport master (
        output req, a, b, c, d, o_ready,
`ifdef RR_ARB_LOCK_EN
        output lock,
`endif
        input  gnt, s1, o, o_valid
    );

    // Arbiter side
    modport slave (
        input  req, a, b, c, d, o_ready,
`ifdef RR_ARB_LOCK_EN
        input  lock,
`endif
        output gnt, s1, o, o_valid
    );

endinterface

`default_nettype wire

// File: rtl/mux_4to1.sv
// ============================================================================
// Module      : mux_4to1
// Description : Combinational 4:1 data multiplexer (select 0=a .. 3=d).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_4to1
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] y
);

    // Pure select, no state
    always_comb begin
        y = a;
        case (sel)
            REQ_A:   y = a;
            REQ_B:   y = b;
            REQ_C:   y = c;
            REQ_D:   y = d;
            default: y = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_4to1.sv
// ============================================================================
// Module      : rr_arb_4to1
// Description : 4-requester round-robin arbiter with a one-word registered
//               output stage (valid/ready). One capture per cycle at most;
//               gnt is combinational and marks the captured requester.
//               Optional macro RR_ARB_LOCK_EN: lock=1 restricts capture to
//               the requester currently shown on s1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb_4to1
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arb_4to1_if.slave bus
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_s1;
    logic [WIDTH-1:0] r_o;
    logic [WIDTH-1:0] w_mux_y;
    logic [N_REQ-1:0] w_req_eff;
    logic [N_REQ-1:0] w_gnt;
    logic             w_cap;
    logic             w_o_valid;
    rr_pick_t         w_pick;

    assign w_o_valid = (r_state == ST_HOLD);

`ifdef RR_ARB_LOCK_EN
    // Lock narrows eligibility to the requester held in s1; if it is idle,
    // nothing is eligible and nothing is captured.
    assign w_req_eff = bus.lock ? (bus.req & (N_REQ'(1) << r_s1)) : bus.req;
`else
    assign w_req_eff = bus.req;
`endif

    assign w_pick = rr_pick(w_req_eff, r_ptr);

    mux_4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .d   (bus.d),
        .sel (w_pick.idx),
        .y   (w_mux_y)
    );

    // Capture decision, grant and next state; everything gated off in reset
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_gnt       = '0;
        if (rst_n) begin
            w_cap = w_pick.found && (!w_o_valid || bus.o_ready);
            if (w_cap) begin
                w_state_nxt = ST_HOLD;
                w_gnt       = N_REQ'(1) << w_pick.idx;
            end else if (w_o_valid && bus.o_ready) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output word, select and round-robin pointer load only on capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_o   <= '0;
            r_s1  <= REQ_A;
            r_ptr <= PTR_RST;
        end else if (w_cap) begin
            r_o   <= w_mux_y;
            r_s1  <= w_pick.idx;
            r_ptr <= w_pick.idx;
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.s1      = r_s1;
    assign bus.o       = r_o;
    assign bus.o_valid = w_o_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_4to1.sv
// ============================================================================
// Module      : tb_rr_arb_4to1
// Description : Self-checking bench for rr_arb_4to1: directed scenarios with
//               constant expectations plus randomized traffic against a
//               behavioural model. Lock scenarios build with RR_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_arb_4to1;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    rr_arb_4to1_if #(.WIDTH(WIDTH)) bus ();

    rr_arb_4to1 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: last winner, held word, valid flag
    int               m_ptr;
    int               m_s1;
    bit               m_valid;
    logic [WIDTH-1:0] m_o;
    // Per-cycle expectations and observed grant
    bit               exp_cap;
    int               exp_win;
    logic [3:0]       exp_gnt;
    logic [WIDTH-1:0] exp_data;
    logic [3:0]       obs_gnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decide this cycle's capture from the current inputs and model state
    task automatic model_eval();
        logic [3:0]       elig;
        logic [WIDTH-1:0] dat [4];
        dat[0] = bus.a; dat[1] = bus.b; dat[2] = bus.c; dat[3] = bus.d;
        elig = bus.req;
`ifdef RR_ARB_LOCK_EN
        if (bus.lock === 1'b1) elig = bus.req & 4'(1 << m_s1);
`endif
        exp_cap  = 1'b0;
        exp_win  = -1;
        exp_gnt  = 4'b0000;
        exp_data = '0;
        if (rst_n === 1'b1 && elig != 4'b0000 && (!m_valid || bus.o_ready === 1'b1)) begin
            for (int k = 1; k <= 4; k++) begin
                if (exp_win < 0 && elig[(m_ptr + k) % 4]) exp_win = (m_ptr + k) % 4;
            end
            exp_cap  = 1'b1;
            exp_gnt  = 4'(1 << exp_win);
            exp_data = dat[exp_win];
        end
    endtask

    // Apply the clock edge to the model
    task automatic model_commit();
        if (rst_n !== 1'b1) begin
            m_ptr = 3; m_s1 = 0; m_valid = 1'b0; m_o = '0;
        end else if (exp_cap) begin
            m_o = exp_data; m_s1 = exp_win; m_ptr = exp_win; m_valid = 1'b1;
        end else if (m_valid && bus.o_ready === 1'b1) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: sample gnt mid-cycle, step the model at the edge, settle
    task automatic run_cycle();
        @(negedge clk);
        model_eval();
        obs_gnt = bus.gnt;
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_data(input logic [WIDTH-1:0] va, vb, vc, vd);
        bus.a = va; bus.b = vb; bus.c = vc; bus.d = vd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.req = 4'b1111; bus.o_ready = 1'b1;
        drive_data(32'hA, 32'hB, 32'hC, 32'hD);
        for (int i = 0; i < 2; i++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 4'b0000) begin
                errors++; $display("FAIL reset_gnt: got %b want 0000", obs_gnt);
            end
            checks++;
            if (bus.o_valid !== 1'b0 || bus.o !== '0 || bus.s1 !== 2'b00) begin
                errors++;
                $display("FAIL reset_out: got v=%b o=%h s1=%0d want v=0 o=0 s1=0",
                         bus.o_valid, bus.o, bus.s1);
            end
        end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; run_cycle();
        rst_n = 1'b1; bus.req = 4'b1111; bus.o_ready = 1'b1;
        drive_data(32'd1, 32'd2, 32'd3, 32'd4);
        for (int k = 0; k < 8; k++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 4'(1 << (k % 4))) begin
                errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, obs_gnt, 4'(1 << (k % 4)));
            end
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o !== 32'((k % 4) + 1) || bus.s1 !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_out[%0d]: got v=%b o=%0d s1=%0d want v=1 o=%0d s1=%0d",
                         k, bus.o_valid, bus.o, bus.s1, (k % 4) + 1, k % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; run_cycle();
        rst_n = 1'b1; bus.req = 4'b0101; bus.o_ready = 1'b1;
        drive_data(32'h11, 32'h22, 32'h33, 32'h44);
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0001 || bus.o !== 32'h11 || bus.o_valid !== 1'b1) begin
            errors++; $display("FAIL bp_first: got gnt=%b o=%h v=%b want 0001 11 1", obs_gnt, bus.o, bus.o_valid);
        end
        bus.o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 4'b0000 || bus.o !== 32'h11 || bus.o_valid !== 1'b1 || bus.s1 !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got gnt=%b o=%h v=%b s1=%0d want 0000 11 1 0",
                         i, obs_gnt, bus.o, bus.o_valid, bus.s1);
            end
        end
        bus.o_ready = 1'b1;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0100 || bus.o !== 32'h33 || bus.s1 !== 2'd2) begin
            errors++; $display("FAIL bp_release: got gnt=%b o=%h s1=%0d want 0100 33 2", obs_gnt, bus.o, bus.s1);
        end
    endtask

    task automatic test_wrap();
        bus.req = 4'b1001; bus.o_ready = 1'b1;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b1000 || bus.s1 !== 2'd3 || bus.o !== 32'h44) begin
            errors++; $display("FAIL wrap_d: got gnt=%b s1=%0d o=%h want 1000 3 44", obs_gnt, bus.s1, bus.o);
        end
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0001 || bus.s1 !== 2'd0 || bus.o !== 32'h11) begin
            errors++; $display("FAIL wrap_a: got gnt=%b s1=%0d o=%h want 0001 0 11", obs_gnt, bus.s1, bus.o);
        end
    endtask

    task automatic test_back_to_back_single();
        bus.req = 4'b0010; bus.o_ready = 1'b1;
        drive_data(32'h1A, 32'h0B, 32'h1C, 32'h1D);
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 4'b0010 || bus.o_valid !== 1'b1 || bus.o !== 32'h0B || bus.s1 !== 2'd1) begin
                errors++;
                $display("FAIL single[%0d]: got gnt=%b v=%b o=%h s1=%0d want 0010 1 0b 1",
                         i, obs_gnt, bus.o_valid, bus.o, bus.s1);
            end
        end
        bus.req = 4'b0000;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0000 || bus.o_valid !== 1'b0 || bus.o !== 32'h0B || bus.s1 !== 2'd1) begin
            errors++;
            $display("FAIL single_drop: got gnt=%b v=%b o=%h s1=%0d want 0000 0 0b 1",
                     obs_gnt, bus.o_valid, bus.o, bus.s1);
        end
    endtask

    task automatic test_reset_hold();
        bus.req = 4'b0001; bus.o_ready = 1'b1;
        run_cycle();
        bus.o_ready = 1'b0;
        run_cycle();
        rst_n = 1'b0; bus.req = 4'b1111;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0000 || bus.o_valid !== 1'b0 || bus.o !== '0 || bus.s1 !== 2'd0) begin
            errors++;
            $display("FAIL rst_hold: got gnt=%b v=%b o=%h s1=%0d want 0000 0 0 0",
                     obs_gnt, bus.o_valid, bus.o, bus.s1);
        end
        rst_n = 1'b1; bus.o_ready = 1'b1;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0001 || bus.o_valid !== 1'b1 || bus.s1 !== 2'd0 || bus.o !== 32'h1A) begin
            errors++;
            $display("FAIL rst_release: got gnt=%b v=%b s1=%0d o=%h want 0001 1 0 1a",
                     obs_gnt, bus.o_valid, bus.s1, bus.o);
        end
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        rst_n = 1'b0; bus.lock = 1'b0; run_cycle();
        rst_n = 1'b1; bus.req = 4'b1111; bus.o_ready = 1'b1;
        drive_data(32'd1, 32'd2, 32'd3, 32'd4);
        for (int i = 0; i < 3; i++) run_cycle();
        bus.lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            checks++;
            if (obs_gnt !== 4'b0100 || bus.s1 !== 2'd2 || bus.o !== 32'd3) begin
                errors++; $display("FAIL lock_hold[%0d]: got gnt=%b s1=%0d o=%0d want 0100 2 3", i, obs_gnt, bus.s1, bus.o);
            end
        end
        bus.lock = 1'b0;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b1000 || bus.s1 !== 2'd3) begin
            errors++; $display("FAIL lock_release: got gnt=%b s1=%0d want 1000 3", obs_gnt, bus.s1);
        end
        bus.lock = 1'b1; bus.req = 4'b0111;
        run_cycle();
        checks++;
        if (obs_gnt !== 4'b0000 || bus.s1 !== 2'd3) begin
            errors++; $display("FAIL lock_idle: got gnt=%b s1=%0d want 0000 3", obs_gnt, bus.s1);
        end
        bus.lock = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            bus.req     = 4'($urandom_range(0, 15));
            bus.o_ready = ($urandom_range(0, 3) != 0);
            drive_data($urandom, $urandom, $urandom, $urandom);
`ifdef RR_ARB_LOCK_EN
            bus.lock    = ($urandom_range(0, 3) == 0);
`endif
            run_cycle();
            checks++;
            if (obs_gnt !== exp_gnt) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, obs_gnt, exp_gnt);
            end
            checks++;
            if (bus.o_valid !== m_valid || bus.o !== m_o || bus.s1 !== 2'(m_s1)) begin
                errors++;
                $display("FAIL rand_out[%0d]: got v=%b o=%h s1=%0d want v=%b o=%h s1=%0d",
                         i, bus.o_valid, bus.o, bus.s1, m_valid, m_o, m_s1);
            end
        end
    endtask

    initial begin
        m_ptr = 3; m_s1 = 0; m_valid = 1'b0; m_o = '0;
        rst_n = 1'b0; bus.req = 4'b0000; bus.o_ready = 1'b0;
        drive_data('0, '0, '0, '0);
`ifdef RR_ARB_LOCK_EN
        bus.lock = 1'b0;
`endif
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_back_to_back_single();
        test_reset_hold();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
